// File: rtl/pc_fetch_pkg.sv
// Shared definitions for the fetch front end: stall bus layout, the IC->ID bus
// record and the fetch exception code position.
package pc_fetch_pkg;

    localparam int          IC_TO_ID_WD      = 65;
    localparam logic [31:0] ZERO_WORD        = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
    localparam int          EXC_ADEL_IF      = 16;

    // Stall bus bit positions: PC stage, IC stage, ID stage.
    localparam int STALL_PC = 0;
    localparam int STALL_IC = 1;
    localparam int STALL_ID = 2;

    typedef logic [5:0] stall_bus_t;

    typedef enum logic {
        NO_STOP = 1'b0,
        STOP    = 1'b1
    } stop_e;

    typedef struct packed {
        logic [31:0] excepttype;
        logic        ce;
        logic [31:0] pc;
    } ic_to_id_t;

    function automatic logic [31:0] fetch_exc(input logic adel);
        fetch_exc              = ZERO_WORD;
        fetch_exc[EXC_ADEL_IF] = adel;
    endfunction

endpackage

// File: rtl/pc_fetch_if.sv
// Fetch-stage bundle: redirect/stall controls in, instruction SRAM drive and
// IC->ID bus out. master = fetch stage, slave = pipeline/SRAM side.
interface pc_fetch_if
    import pc_fetch_pkg::*;
    ;

    stall_bus_t             stall;
    logic                   flush;
    logic [31:0]            new_pc;
    logic                   br_e;
    logic [31:0]            br_addr;
    logic                   inst_sram_en;
    logic [31:0]            inst_sram_addr;
    logic [IC_TO_ID_WD-1:0] ic_to_id_bus;

    modport master (
        input  stall, flush, new_pc, br_e, br_addr,
        output inst_sram_en, inst_sram_addr, ic_to_id_bus
    );

    modport slave (
        output stall, flush, new_pc, br_e, br_addr,
        input  inst_sram_en, inst_sram_addr, ic_to_id_bus
    );

endinterface

// File: rtl/pc_fetch_redirect_buf.sv
// Holds one branch target that arrived while the PC stage was stalled, until
// the PC stage can consume it. Flush discards it.
module pc_redirect_buf (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        hold,
    input  logic        br_e,
    input  logic [31:0] br_addr,
    output logic        pend_v,
    output logic [31:0] pend_pc
);

    logic set_pend;
    logic consume;

    // A second taken branch while one is pending cannot happen, so it is ignored.
    assign set_pend = hold & br_e & ~pend_v & ~flush;
    assign consume  = ~hold & pend_v;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst || flush || consume) begin
            pend_v <= 1'b0;
        end else if (set_pend) begin
            pend_v <= 1'b1;
        end
    end

    // NOTE: pend_pc is a data-only register qualified by pend_v, so it is
    // deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (set_pend) begin
            pend_pc <= br_addr;
        end
    end

endmodule

// File: rtl/pc_fetch.sv
// PC generation and instruction-cache access stages (0 and 1).
// FETCH_ADEL_CHECK_EN enables the misaligned-fetch AdEL check.
module pc_fetch
    import pc_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    pc_fetch_if.master bus
);

    logic [31:0] pc_reg;
    logic [31:0] pc_next;
    logic        ce_reg;
    logic        pend_v;
    logic [31:0] pend_pc;
    logic        adel;
    logic        stall_pc;
    logic        stall_ic;
    logic        stall_id;
    logic        unused_stall_hi;
    ic_to_id_t   ic_q;
    ic_to_id_t   ic_fetch;
    logic        ic_bubble;

    assign stall_pc        = (bus.stall[STALL_PC] == STOP);
    assign stall_ic        = (bus.stall[STALL_IC] == STOP);
    assign stall_id        = (bus.stall[STALL_ID] == STOP);
    assign unused_stall_hi = ^bus.stall[5:3];

`ifdef FETCH_ADEL_CHECK_EN
    assign adel               = (pc_reg[1:0] != 2'b00);
    assign bus.inst_sram_addr = pc_reg;
`else
    assign adel               = 1'b0;
    assign bus.inst_sram_addr = {pc_reg[31:2], 2'b00};
`endif

    assign bus.inst_sram_en = ce_reg & ~adel;

    pc_redirect_buf u_redirect_buf (
        .clk     (clk),
        .rst     (rst),
        .flush   (bus.flush),
        .hold    (stall_pc),
        .br_e    (bus.br_e),
        .br_addr (bus.br_addr),
        .pend_v  (pend_v),
        .pend_pc (pend_pc)
    );

    // NOTE: defaulting pc_next before any branch keeps this block free of latches.
    always_comb begin
        pc_next = pc_reg;
        if (bus.flush) begin
            pc_next = bus.new_pc;
        end else if (!stall_pc) begin
            if (pend_v) begin
                pc_next = pend_pc;
            end else if (bus.br_e) begin
                pc_next = bus.br_addr;
            end else if (ce_reg) begin
                // The first edge after reset only turns fetch on, so RESET_PC is fetched first.
                pc_next = pc_reg + 32'd4;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg <= RESET_PC;
            ce_reg <= 1'b0;
        end else begin
            pc_reg <= pc_next;
            ce_reg <= 1'b1;
        end
    end

    // The fetch at pc_reg is wrong-path whenever a redirect is being taken.
    always_comb begin
        ic_fetch.excepttype = fetch_exc(adel);
        ic_fetch.ce         = ce_reg;
        ic_fetch.pc         = pc_reg;
        ic_bubble = rst || bus.flush
                 || (!stall_ic && (bus.br_e || pend_v))
                 || (stall_ic && !stall_id);
    end

    always_ff @(posedge clk) begin
        if (ic_bubble) begin
            ic_q <= '0;
        end else if (!stall_ic) begin
            ic_q <= ic_fetch;
        end
    end

    assign bus.ic_to_id_bus = ic_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch: directed vector table for the documented
// scenarios, then randomized stimulus against a queue-based reference model.
module tb_pc_fetch;
    import pc_fetch_pkg::*;

`ifdef FETCH_ADEL_CHECK_EN
    localparam bit ADEL_ON = 1'b1;
`else
    localparam bit ADEL_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    pc_fetch_if bus ();

    pc_fetch #(.RESET_PC(32'hBFC0_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        rst;
        logic [5:0]  stall;
        logic        flush;
        logic [31:0] new_pc;
        logic        br_e;
        logic [31:0] br_addr;
        logic [31:0] exp_addr;
        logic        exp_en;
        logic [31:0] exp_ic_pc;
        logic        exp_ic_ce;
        logic [31:0] exp_exc;
    } vec_t;

    // Reference model state: architectural PC, whether fetching has started,
    // a queue of deferred branch targets and the expected IC record.
    logic [31:0] m_pc       = 32'hBFC0_0000;
    bit          m_fetching = 1'b0;
    logic [31:0] m_pend[$];
    ic_to_id_t   m_ic       = '0;

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic [5:0] st, input logic fl,
                                input logic [31:0] np, input logic be, input logic [31:0] ba,
                                input logic [31:0] ea, input logic een, input logic [31:0] ep,
                                input logic ece, input logic [31:0] eex);
        vec_t v;
        v.rst = r; v.stall = st; v.flush = fl; v.new_pc = np; v.br_e = be; v.br_addr = ba;
        v.exp_addr = ea; v.exp_en = een; v.exp_ic_pc = ep; v.exp_ic_ce = ece; v.exp_exc = eex;
        return v;
    endfunction

    function automatic bit misaligned(input logic [31:0] a);
        return ADEL_ON && (a % 4 != 0);
    endfunction

    // Advance the model by one clock edge from the stimulus about to be applied.
    task automatic model_step(input vec_t v);
        logic [31:0] pc_now     = m_pc;
        bit          redirecting = v.br_e || (m_pend.size() != 0);
        if (v.rst || v.flush)                    m_ic = '0;
        else if (!v.stall[1] && redirecting)     m_ic = '0;
        else if (v.stall[1] && !v.stall[2])      m_ic = '0;
        else if (!v.stall[1]) begin
            m_ic.excepttype = misaligned(pc_now) ? 32'h0001_0000 : 32'h0;
            m_ic.ce         = m_fetching;
            m_ic.pc         = pc_now;
        end
        if (v.rst) begin
            m_pc = 32'hBFC0_0000;
            m_fetching = 1'b0;
            m_pend.delete();
        end else begin
            if (v.flush) begin
                m_pc = v.new_pc;
                m_pend.delete();
            end else if (!v.stall[0]) begin
                if (m_pend.size() != 0) m_pc = m_pend.pop_front();
                else if (v.br_e)        m_pc = v.br_addr;
                else if (m_fetching)    m_pc = m_pc + 32'd4;
            end else if (v.br_e && m_pend.size() == 0) begin
                m_pend.push_back(v.br_addr);
            end
            m_fetching = 1'b1;
        end
    endtask

    task automatic apply(input vec_t v);
        rst         = v.rst;
        bus.stall   = v.stall;
        bus.flush   = v.flush;
        bus.new_pc  = v.new_pc;
        bus.br_e    = v.br_e;
        bus.br_addr = v.br_addr;
        model_step(v);
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[$];

    initial begin
        ic_to_id_t got;
        rst = 1'b1; bus.stall = '0; bus.flush = 1'b0; bus.new_pc = '0;
        bus.br_e = 1'b0; bus.br_addr = '0;

        // Reset release and sequential fetch
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(1, 6'h00, 0, 0, 0, 0, 32'hBFC0_0000, 0, 32'h0, 0, 0));
        tbl.push_back(mk(0, 6'h00, 0, 0, 0, 0, 32'hBFC0_0000, 1, 32'hBFC0_0000, 0, 0));
        tbl.push_back(mk(0, 6'h00, 0, 0, 0, 0, 32'hBFC0_0004, 1, 32'hBFC0_0000, 1, 0));
        tbl.push_back(mk(0, 6'h00, 0, 0, 0, 0, 32'hBFC0_0008, 1, 32'hBFC0_0004, 1, 0));
        tbl.push_back(mk(0, 6'h00, 0, 0, 0, 0, 32'hBFC0_000C, 1, 32'hBFC0_0008, 1, 0));
        tbl.push_back(mk(0, 6'h00, 0, 0, 0, 0, 32'hBFC0_0010, 1, 32'hBFC0_000C, 1, 0));
        // Taken branch at BFC00010
        tbl.push_back(mk(0, 6'h00, 0, 0, 1, 32'h8000_1000, 32'h8000_1000, 1, 32'h0, 0, 0));
        tbl.push_back(mk(0, 6'h00, 0, 0, 0, 0, 32'h8000_1004, 1, 32'h8000_1000, 1, 0));
        // Branch under a 3-cycle stall
        tbl.push_back(mk(0, 6'h03, 0, 0, 1, 32'h8000_2000, 32'h8000_1004, 1, 32'h0, 0, 0));
        tbl.push_back(mk(0, 6'h03, 0, 0, 0, 0, 32'h8000_1004, 1, 32'h0, 0, 0));
        tbl.push_back(mk(0, 6'h03, 0, 0, 0, 0, 32'h8000_1004, 1, 32'h0, 0, 0));
        tbl.push_back(mk(0, 6'h00, 0, 0, 0, 0, 32'h8000_2000, 1, 32'h0, 0, 0));
        tbl.push_back(mk(0, 6'h00, 0, 0, 0, 0, 32'h8000_2004, 1, 32'h8000_2000, 1, 0));
        // Pending redirect, then flush together with a branch
        tbl.push_back(mk(0, 6'h01, 0, 0, 1, 32'h8000_3000, 32'h8000_2004, 1, 32'h0, 0, 0));
        tbl.push_back(mk(0, 6'h00, 1, 32'hBFC0_0380, 1, 32'h8000_4000, 32'hBFC0_0380, 1, 32'h0, 0, 0));
        tbl.push_back(mk(0, 6'h00, 0, 0, 0, 0, 32'hBFC0_0384, 1, 32'hBFC0_0380, 1, 0));
        // Wrap-around
        tbl.push_back(mk(0, 6'h00, 1, 32'hFFFF_FFFC, 0, 0, 32'hFFFF_FFFC, 1, 32'h0, 0, 0));
        tbl.push_back(mk(0, 6'h00, 0, 0, 0, 0, 32'h0000_0000, 1, 32'hFFFF_FFFC, 1, 0));
        tbl.push_back(mk(0, 6'h00, 0, 0, 0, 0, 32'h0000_0004, 1, 32'h0000_0000, 1, 0));
        // IC and ID both stalled: everything holds
        tbl.push_back(mk(0, 6'h07, 0, 0, 0, 0, 32'h0000_0004, 1, 32'h0000_0000, 1, 0));
        // Misaligned branch target
        tbl.push_back(mk(0, 6'h00, 0, 0, 1, 32'h8000_0002,
                         ADEL_ON ? 32'h8000_0002 : 32'h8000_0000, !ADEL_ON, 32'h0, 0, 0));
        tbl.push_back(mk(0, 6'h00, 0, 0, 0, 0,
                         ADEL_ON ? 32'h8000_0006 : 32'h8000_0004, !ADEL_ON, 32'h8000_0002, 1,
                         ADEL_ON ? 32'h0001_0000 : 32'h0));
        // Reset while a redirect is pending leaves no residue
        tbl.push_back(mk(0, 6'h01, 0, 0, 1, 32'h8000_5000,
                         ADEL_ON ? 32'h8000_0006 : 32'h8000_0004, !ADEL_ON, 32'h0, 0, 0));
        tbl.push_back(mk(1, 6'h01, 0, 0, 0, 0, 32'hBFC0_0000, 0, 32'h0, 0, 0));
        tbl.push_back(mk(0, 6'h00, 0, 0, 0, 0, 32'hBFC0_0000, 1, 32'hBFC0_0000, 0, 0));
        tbl.push_back(mk(0, 6'h00, 0, 0, 0, 0, 32'hBFC0_0004, 1, 32'hBFC0_0000, 1, 0));

        foreach (tbl[i]) begin
            apply(tbl[i]);
            got = bus.ic_to_id_bus;
            check($sformatf("row%0d addr", i), bus.inst_sram_addr, tbl[i].exp_addr);
            check($sformatf("row%0d en", i), bus.inst_sram_en, tbl[i].exp_en);
            check($sformatf("row%0d ic_pc", i), got.pc, tbl[i].exp_ic_pc);
            check($sformatf("row%0d ic_ce", i), got.ce, tbl[i].exp_ic_ce);
            check($sformatf("row%0d exc", i), got.excepttype, tbl[i].exp_exc);
        end

        // Randomized traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            vec_t v;
            logic [31:0] a;
            logic [31:0] b;
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
            if ($urandom_range(0, 7) != 0) b[1:0] = 2'b00;
            v = mk($urandom_range(0, 49) == 0,
                   {3'($urandom), 1'($urandom_range(0, 3) == 0),
                    1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) == 0)},
                   $urandom_range(0, 19) == 0, b, $urandom_range(0, 4) == 0, a,
                   0, 0, 0, 0, 0);
            apply(v);
            check($sformatf("rnd%0d addr", n), bus.inst_sram_addr,
                  ADEL_ON ? m_pc : {m_pc[31:2], 2'b00});
            check($sformatf("rnd%0d en", n), bus.inst_sram_en,
                  m_fetching && !misaligned(m_pc));
            check($sformatf("rnd%0d ic_bus", n), bus.ic_to_id_bus, m_ic);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_fetch.md
# pc_fetch

PC-generation and instruction-cache-access stages (pipeline stages 0 and 1) of the single-issue MIPS core. It holds the fetch PC and drives the instruction SRAM. It registers the fetched PC, valid flag and fetch-exception bits into `ic_to_id_bus`, which the ID stage latches together with the SRAM read data `ic_inst`. It applies flush and branch redirects, and holds a branch target that arrives while stage 0 is stalled.

## Interface
Parameters:
- `RESET_PC`, 32'hBFC0_0000, first fetch address after reset.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset; synchronous, active-high.
- `stall` in 6: `StallBus`.
  - [0] is the PC stage, [1] is the IC stage, [2] is the ID stage.
  - 1 = Stop.
- `flush` in 1: exception/eret flush from CP0.
- `new_pc` in 32: flush target.
- `br_e` in 1: branch/jump taken; driven from EX.
- `br_addr` in 32: branch target.
- `inst_sram_en` out 1: SRAM read enable.
- `inst_sram_addr` out 32: SRAM read address. The SRAM is synchronous with 1-cycle read latency.
- `ic_to_id_bus` out 65 (`IC_TO_ID_WD`): {excepttype[31:0], ic_ce, ic_pc[31:0]}.

## Operation
- **Stage 0 registers:** `pc_reg` (32), `ce_reg` (1), `pend_v` (1), `pend_pc` (32).
- **Stage 1 registers:** `ic_pc`, `ic_ce`, `ic_exc` (32).
- **SRAM drive:** `inst_sram_addr` = `pc_reg`. `inst_sram_en` = `ce_reg & ~adel`.
- **Fetch address error:** `adel` = (`pc_reg[1:0]` != 0). It is gated by the configuration macro.
- **`pc_reg` update, priority high to low:**
  1. `rst`: `pc_reg`←`RESET_PC`, `ce_reg`←0, `pend_v`←0.
  2. `flush`: `pc_reg`←`new_pc`, `pend_v`←0. This ignores `stall`.
  3. `stall[0]`=0 and `pend_v`: `pc_reg`←`pend_pc`, `pend_v`←0.
  4. `stall[0]`=0 and `br_e`: `pc_reg`←`br_addr`.
  5. `stall[0]`=0: `pc_reg`←`pc_reg`+4. Wrap-around modulo 2^32 with no exception.
  6. `stall[0]`=1, `br_e`=1, `pend_v`=0: `pend_pc`←`br_addr`, `pend_v`←1. `pc_reg` holds.
  7. Otherwise hold.
- **`ce_reg`:** ←1 on every non-reset cycle.
- **Pending redirect:** `br_e` while `pend_v`=1 is ignored. EX cannot issue a second taken branch before the first redirect completes.
- **IC register update, priority high to low:**
  1. `rst` or `flush`: load bubble. A bubble is `ic_ce`=0, `ic_pc`=0, `ic_exc`=0.
  2. `stall[1]`=0 and (`br_e` or `pend_v`): load bubble. The fetch at `pc_reg` is wrong-path.
  3. `stall[1]`=1 and `stall[2]`=0: load bubble.
  4. `stall[1]`=0: `ic_pc`←`pc_reg`, `ic_ce`←`ce_reg`, `ic_exc`←{15'b0, `adel`, 16'b0}.
  5. Otherwise hold.
- **Exception bit:** `excepttype` bit 16 = instruction-fetch AdEL. Bits [7:1] are reserved for fetch-side causes and are driven 0.

## Timing
- **Reset values:**
  - `inst_sram_en` = 0 and `inst_sram_addr` = `RESET_PC` during and in the cycle after `rst`.
  - `ic_to_id_bus` = 0.
- **First fetch after `rst` deasserts:**
  - Cycle 0 (first non-reset edge): `ce_reg`←1, `pc_reg`←`RESET_PC`+4.
  - Correction: because of item 5, the first non-reset edge with `ce_reg`=0 holds `pc_reg`. Only edges where `ce_reg` was already 1 advance the PC.
  - Result: `RESET_PC` is fetched first.
- **Fetch latency:** the PC is presented to the SRAM in cycle n. `ic_pc` equals that PC and `ic_inst` is valid in cycle n+1.
- **`br_e` latency:**
  - Asserted in cycle n with no stall: the target is on `inst_sram_addr` in cycle n+1.
  - Asserted under `stall[0]`: the target is on `inst_sram_addr` in the cycle after `stall[0]` falls.
- **`flush` latency:** `new_pc` is on `inst_sram_addr` in the next cycle. Any pending redirect is discarded.
- **Simultaneous events:**
  - `flush` and `br_e`: `flush` wins.
  - `rst` mid-stall or mid-pending: full reset, no residual redirect.

## Configuration
- `FETCH_ADEL_CHECK_EN` defined:
  - `adel` is computed as above.
  - A misaligned PC suppresses `inst_sram_en` and sets `excepttype[16]`.
- Undefined:
  - `adel` = 0.
  - `inst_sram_addr` = {`pc_reg[31:2]`, 2'b00}.
  - `excepttype` is always 0.

## Structure
- Shared package / `lib/defines.vh`:
  - `StallBus`, `Stop`/`NoStop`, `IC_TO_ID_WD` (=65), `ZeroWord`.
  - Excode bit index `EXC_ADEL_IF` = 16.
  - `RESET_PC` default.
- One natural sub-module: `pc_redirect_buf`, holding `pend_v`/`pend_pc` with set/clear/consume logic.

## Test plan
- **Reset release:** `rst` for 3 cycles, then no stalls → `inst_sram_addr` sequence BFC00000, BFC00004, BFC00008. `ic_pc` trails by 1 cycle. `ic_ce`=0 until the first fetch lands.
- **Taken branch:** `br_e`=1, `br_addr`=80001000 while `pc_reg`=BFC00010 → next `inst_sram_addr`=80001000. `ic_to_id_bus` is a bubble in that cycle. Then 80001004.
- **Branch under stall:** `stall`=6'b000011 for 3 cycles; `br_e` pulses in the first of them with `br_addr`=80002000 → `pc_reg` holds. One cycle after the stall falls, `inst_sram_addr`=80002000. The IC captures only bubbles until then.
- **Flush over branch:** `flush`=1, `new_pc`=BFC00380 with `br_e`=1 and `pend_v`=1 → `inst_sram_addr`=BFC00380, `pend_v`=0, `ic_to_id_bus`=0.
- **Misaligned fetch (macro on):** `br_addr`=80000002 → `inst_sram_en`=0 and `excepttype`=32'h0001_0000 with `ic_pc`=80000002. With the macro off: `inst_sram_addr`=80000000, `excepttype`=0.
- **Wrap:** `flush` to FFFFFFFC → next address 00000000, no exception.
